// File: rtl/char_serial_rx.sv
// char_serial_rx
//   Asynchronous-serial character receiver feeding the 8-bit case-conversion stage.
//   Each frame is a start bit, 8 data bits and a stop bit.
//   The data bits are assembled MSB-first, so the first data bit on the line
//   ends up in out_data[7].
//   Completed bytes are queued in a small FIFO and offered with a valid/ready
//   handshake. Framing errors and overruns are reported as single-cycle pulses.
//   Optional feature macro: RX_PARITY_EN. When defined, an even-parity bit is
//   expected between the last data bit and the stop bit, giving an 11-bit frame.
module char_serial_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx_serial,
    output logic [7:0]                  out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        frame_err,
    output logic                        overrun
);
    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_FW = PTR_W + 1;
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 32'd2 - 32'd1);
    localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 32'd1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1'b1);
    localparam logic [CNT_FW-1:0] DEPTH_C = CNT_FW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

`ifdef RX_PARITY_EN
    // Even parity: data bits plus parity bit carry an even number of ones.
    function automatic logic even_parity_bit(input logic [7:0] d);
        return ^d;
    endfunction
`endif

    logic              sync1_r, sync2_r, rxs_s;
    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  bit_cnt_r, bit_cnt_nxt_s;
    logic [2:0]        bit_idx_r, bit_idx_nxt_s;
    logic [7:0]        shift_r, shift_nxt_s;
    logic              push_req_s, frame_err_s;
`ifdef RX_PARITY_EN
    logic              par_bit_r, par_nxt_s;
`endif

    logic [7:0]        mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_r, wr_ptr_r, rd_ptr_nxt_s, wr_ptr_nxt_s;
    logic [CNT_FW-1:0] count_r, count_nxt_s;
    logic [7:0]        out_data_r, data_nxt_s;
    logic              out_valid_r, frame_err_r, overrun_r;
    logic              pop_s, full_s, push_ok_s, overrun_s;

    assign rxs_s = sync2_r;

    // Two-flop synchronizer for the asynchronous serial line (idles high).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx_serial;
            sync2_r <= sync1_r;
        end
    end

    // Receive FSM next-state: bit timing, mid-bit sampling and frame checks.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
`ifdef RX_PARITY_EN
        par_nxt_s     = par_bit_r;
`endif
        push_req_s    = 1'b0;
        frame_err_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                bit_cnt_nxt_s = {CNT_W{1'b0}};
                bit_idx_nxt_s = 3'd0;
                if (!rxs_s) begin
                    state_nxt_s = S_START;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_START: begin
                if (bit_cnt_r == HALF_M1) begin
                    bit_cnt_nxt_s = {CNT_W{1'b0}};
                    // A start bit that is already gone at mid-bit was a glitch.
                    if (rxs_s) begin
                        state_nxt_s = S_IDLE;
                    end else begin
                        state_nxt_s = S_DATA;
                    end
                end else begin
                    bit_cnt_nxt_s = bit_cnt_r + CNT_ONE;
                end
            end
            S_DATA: begin
                if (bit_cnt_r == FULL_M1) begin
                    bit_cnt_nxt_s = {CNT_W{1'b0}};
                    shift_nxt_s   = {shift_r[6:0], rxs_s};
                    if (bit_idx_r == 3'd7) begin
                        bit_idx_nxt_s = 3'd0;
`ifdef RX_PARITY_EN
                        state_nxt_s   = S_PARITY;
`else
                        state_nxt_s   = S_STOP;
`endif
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    bit_cnt_nxt_s = bit_cnt_r + CNT_ONE;
                end
            end
`ifdef RX_PARITY_EN
            S_PARITY: begin
                if (bit_cnt_r == FULL_M1) begin
                    bit_cnt_nxt_s = {CNT_W{1'b0}};
                    par_nxt_s     = rxs_s;
                    state_nxt_s   = S_STOP;
                end else begin
                    bit_cnt_nxt_s = bit_cnt_r + CNT_ONE;
                end
            end
`endif
            S_STOP: begin
                if (bit_cnt_r == FULL_M1) begin
                    bit_cnt_nxt_s = {CNT_W{1'b0}};
`ifdef RX_PARITY_EN
                    push_req_s  = rxs_s & (even_parity_bit(shift_r) == par_bit_r);
                    frame_err_s = ~push_req_s;
`else
                    push_req_s  = rxs_s;
                    frame_err_s = ~rxs_s;
`endif
                    // A low stop bit means the line may still be held low.
                    if (rxs_s) begin
                        state_nxt_s = S_IDLE;
                    end else begin
                        state_nxt_s = S_BREAK;
                    end
                end else begin
                    bit_cnt_nxt_s = bit_cnt_r + CNT_ONE;
                end
            end
            S_BREAK: begin
                bit_cnt_nxt_s = {CNT_W{1'b0}};
                if (rxs_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_BREAK;
                end
            end
            default: begin
                state_nxt_s   = S_IDLE;
                bit_cnt_nxt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // Receive FSM state and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= S_IDLE;
            bit_cnt_r <= {CNT_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
`ifdef RX_PARITY_EN
            par_bit_r <= 1'b0;
`endif
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
`ifdef RX_PARITY_EN
            par_bit_r <= par_nxt_s;
`endif
        end
    end

    // FIFO control: a pop in the same cycle frees the slot for a push, even when full.
    always_comb begin
        pop_s        = (count_r != {CNT_FW{1'b0}}) & out_ready;
        full_s       = (count_r == DEPTH_C);
        push_ok_s    = push_req_s & (~full_s | pop_s);
        overrun_s    = push_req_s & full_s & ~pop_s;
        rd_ptr_nxt_s = pop_s ? (rd_ptr_r + PTR_ONE) : rd_ptr_r;
        wr_ptr_nxt_s = push_ok_s ? (wr_ptr_r + PTR_ONE) : wr_ptr_r;
        count_nxt_s  = count_r + CNT_FW'(push_ok_s) - CNT_FW'(pop_s);
        // The next head comes straight from the shifter when it lands in the head slot.
        if (count_nxt_s == {CNT_FW{1'b0}}) begin
            data_nxt_s = out_data_r;
        end else if (push_ok_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            data_nxt_s = shift_r;
        end else begin
            data_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // FIFO storage write.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok_s) begin
            mem_r[wr_ptr_r] <= shift_r;
        end else begin
            mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
        end
    end

    // FIFO pointers, occupancy and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_r    <= {PTR_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {CNT_FW{1'b0}};
            out_data_r  <= 8'h00;
            out_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            rd_ptr_r    <= rd_ptr_nxt_s;
            wr_ptr_r    <= wr_ptr_nxt_s;
            count_r     <= count_nxt_s;
            out_data_r  <= data_nxt_s;
            out_valid_r <= (count_nxt_s != {CNT_FW{1'b0}});
            frame_err_r <= frame_err_s;
            overrun_r   <= overrun_s;
        end
    end

    assign out_data   = out_data_r;
    assign out_valid  = out_valid_r;
    assign fifo_count = count_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_char_serial_rx.sv
// Testbench for char_serial_rx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Stimulus pushes expected bytes into a queue; a monitor process pops and
// compares on every handshake and counts error pulses.
// Define RX_PARITY_EN for both files to exercise the parity build.
module tb_char_serial_rx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       rx_serial = 1'b1;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_valid;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overrun;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    logic [7:0] exp_q[$];

    char_serial_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rx_serial(rx_serial),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_count(fifo_count), .frame_err(frame_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one frame, starting at a negedge; returns at a negedge with the line idle.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            rx_serial = d[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef RX_PARITY_EN
        rx_serial = par_bit;
        repeat (CPB) @(negedge clk);
`endif
        rx_serial = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_serial = 1'b1;
    endtask

    task automatic send_good(input logic [7:0] d, input logic expect_push);
        if (expect_push) exp_q.push_back(d);
        send_frame(d, 1'b1, ^d);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        #1;
        check({name, "_queue_empty"}, exp_q.size(), 0);
        check({name, "_valid_low"}, out_valid, 1'b0);
    endtask

    // Scoreboard monitor: compare on each handshake, count error pulses.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pop: got %02h with no byte expected", out_data);
                    end else begin
                        check("pop_data", out_data, exp_q.pop_front());
                    end
                end
                if (frame_err) fe_cnt++;
                if (overrun) ov_cnt++;
                if (frame_err || overrun) check("pulse_exclusive", frame_err & overrun, 1'b0);
            end
        end
    end

    // Watchdog.
    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fe0, ov0;
        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_fifo_count", fifo_count, 3'd0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: single byte, consumer ready: visible for exactly one cycle
        fe0 = fe_cnt; ov0 = ov_cnt;
        out_ready = 1'b1;
        send_good(8'h61, 1'b1);
        @(negedge clk); #1;
        check("t1_valid_hi", out_valid, 1'b1);
        check("t1_count_1", fifo_count, 3'd1);
        check("t1_data", out_data, 8'h61);
        @(negedge clk); #1;
        check("t1_valid_lo", out_valid, 1'b0);
        check("t1_count_0", fifo_count, 3'd0);
        check("t1_data_held", out_data, 8'h61);
        repeat (4) @(negedge clk);
        check("t1_no_fe", fe_cnt - fe0, 0);
        check("t1_no_ov", ov_cnt - ov0, 0);

        // 2: one-cycle low glitch is ignored
        fe0 = fe_cnt;
        rx_serial = 1'b0;
        @(negedge clk);
        rx_serial = 1'b1;
        repeat (12) @(negedge clk); #1;
        check("t2_valid", out_valid, 1'b0);
        check("t2_no_fe", fe_cnt - fe0, 0);
        send_good(8'h5A, 1'b1);
        drain("t2");

        // 3: bad stop bit -> frame error, no push; next byte fine
        fe0 = fe_cnt;
        send_frame(8'h7A, 1'b0, ^8'h7A);
        repeat (2) @(negedge clk); #1;
        check("t3_fe_pulse", fe_cnt - fe0, 1);
        check("t3_no_push", fifo_count, 3'd0);
        repeat (8) @(negedge clk);
        send_good(8'h41, 1'b1);
        drain("t3");

        // 4: overrun on fifth byte while consumer stalled
        ov0 = ov_cnt;
        out_ready = 1'b0;
        send_good(8'h61, 1'b1);
        send_good(8'h62, 1'b1);
        send_good(8'h63, 1'b1);
        send_good(8'h64, 1'b1);
        send_good(8'h65, 1'b0);
        repeat (2) @(negedge clk); #1;
        check("t4_count_full", fifo_count, 3'd4);
        check("t4_overrun", ov_cnt - ov0, 1);
        check("t4_head", out_data, 8'h61);
        @(negedge clk);
        out_ready = 1'b1;
        drain("t4");

        // 5: full FIFO, pop coincides with stop-bit sample -> no overrun
        ov0 = ov_cnt;
        out_ready = 1'b0;
        send_good(8'h71, 1'b1);
        send_good(8'h72, 1'b1);
        send_good(8'h73, 1'b1);
        send_good(8'h74, 1'b1);
        exp_q.push_back(8'h75);
        fork
            send_frame(8'h75, 1'b1, ^8'h75);
            begin
                repeat (FRAME_BITS * CPB) @(negedge clk);
                out_ready = 1'b1;
                @(negedge clk);
                out_ready = 1'b0;
            end
        join
        @(negedge clk); #1;
        check("t5_count_full", fifo_count, 3'd4);
        check("t5_no_overrun", ov_cnt - ov0, 0);
        @(negedge clk);
        out_ready = 1'b1;
        drain("t5");

        // 6: reset mid-DATA with two bytes queued
        out_ready = 1'b0;
        send_good(8'h11, 1'b1);
        send_good(8'h22, 1'b1);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        rx_serial = 1'b1;
        repeat (CPB) @(negedge clk);
        rx_serial = 1'b0;
        repeat (CPB) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rx_serial = 1'b1;
        #1;
        check("t6_valid", out_valid, 1'b0);
        check("t6_count", fifo_count, 3'd0);
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
        send_good(8'h30, 1'b1);
        drain("t6");

`ifdef RX_PARITY_EN
        // 7: even parity -- 0x61 has three ones, so a parity bit of 1 is correct
        fe0 = fe_cnt;
        exp_q.push_back(8'h61);
        send_frame(8'h61, 1'b1, 1'b1);
        drain("t7_good");
        send_frame(8'h61, 1'b1, 1'b0);
        repeat (2) @(negedge clk); #1;
        check("t7_fe_pulse", fe_cnt - fe0, 1);
        check("t7_no_push", fifo_count, 3'd0);
        exp_q.push_back(8'h60);
        send_frame(8'h60, 1'b1, 1'b0);
        drain("t7_even");
`endif

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
